// File: rtl/dbus_pkg.sv
// Shared types and constants for the Wishbone data-bus master.
// The watchdog default applies only when DBUS_TIMEOUT_EN is defined.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dbus_state_e;

  localparam int DBUS_TIMEOUT_DEF = 256;

endpackage

// File: rtl/dbus_watchdog.sv
// Cycle counter for the data-bus master: clear, count enable, expiry.
// Instantiated only in builds with DBUS_TIMEOUT_EN defined.
module dbus_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Expires on the BUSY cycle whose increment would reach LIMIT.
  assign expired = (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/dbus_wb_master.sv
// Single-beat Wishbone classic master for the CPU data bus.
// Optional hung-cycle watchdog: define DBUS_TIMEOUT_EN.
module dbus_wb_master
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DBUS_TIMEOUT_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_flush_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  dbus_state_e state_q, state_d;

  logic        drop_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;

  logic accept;
  logic ack_hit;
  logic abort;
  logic expired;

  logic is_idle, is_busy, is_done;

  assign is_idle = (state_q == IDLE);
  assign is_busy = (state_q == BUSY);
  assign is_done = (state_q == DONE);

`ifdef DBUS_TIMEOUT_EN
  dbus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (accept),
    .en      (is_busy & ~wb_ack_i),
    .expired (expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^16'(TIMEOUT_CYCLES);
  assign expired    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack_hit = 1'b0;
    abort   = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (cpu_req_i && !cpu_flush_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      is_busy: begin
        if (wb_ack_i) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      is_done: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      if (accept) begin
        we_q  <= cpu_we_i;
        adr_q <= {cpu_addr_i[31:2], 2'b00};
        sel_q <= cpu_sel_i;
        dat_q <= cpu_wdata_i;
      end
      if (ack_hit) begin
        rdata_q <= we_q ? 32'd0 : wb_dat_i;
        err_q   <= 1'b0;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      // The bus cycle always finishes; a flush only hides its result.
      if (is_done) begin
        drop_q <= 1'b0;
      end else if (is_busy && cpu_flush_i) begin
        drop_q <= 1'b1;
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^cpu_addr_i[1:0];

  assign wb_cyc_o    = is_busy;
  assign wb_stb_o    = is_busy;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;

  assign cpu_stall_o = (is_idle & cpu_req_i & ~cpu_flush_i) | is_busy;
  assign cpu_done_o  = is_done & ~drop_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;

endmodule

// File: tb/tb_dbus_wb_master.sv
// Directed bench for dbus_wb_master; the timeout scenario runs
// only when DBUS_TIMEOUT_EN is defined.
module tb_dbus_wb_master;

`ifdef DBUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        cyc, stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat;
  logic [31:0] wb_din = '0;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;

  dbus_wb_master #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cpu_req_i   (req),
    .cpu_we_i    (we),
    .cpu_addr_i  (addr),
    .cpu_sel_i   (sel),
    .cpu_wdata_i (wdata),
    .cpu_flush_i (flush),
    .cpu_stall_o (stall),
    .cpu_rdata_o (rdata),
    .cpu_done_o  (done),
    .cpu_err_o   (err),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_sel_o    (wb_sel),
    .wb_dat_o    (wb_dat),
    .wb_dat_i    (wb_din),
    .wb_ack_i    (ack)
  );

  always @(posedge clk) if (done) done_cnt++;
  always @(posedge cyc) cyc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  int d0, c0;
  int dly[3] = '{0, 3, 7};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);

    // ack while idle must be ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    settle();
    chk("stray_ack_cyc", {31'd0, cyc}, 32'd0);
    chk("stray_ack_done", {31'd0, done}, 32'd0);

    // load, immediate ack
    req = 1'b1; we = 1'b0; addr = 32'h0000_1006; sel = 4'b1100;
    settle();
    chk("ld_c0_stall", {31'd0, stall}, 32'd1);
    chk("ld_c0_cyc", {31'd0, cyc}, 32'd0);
    tick();
    settle();
    chk("ld_c1_cyc", {30'd0, cyc, stb}, 32'd3);
    chk("ld_c1_adr", wb_adr, 32'h0000_1004);
    chk("ld_c1_sel", {28'd0, wb_sel}, 32'hC);
    chk("ld_c1_we", {31'd0, wb_we}, 32'd0);
    chk("ld_c1_stall", {31'd0, stall}, 32'd1);
    ack = 1'b1; wb_din = 32'hDEADBEEF;
    tick();
    ack = 1'b0; req = 1'b0;
    settle();
    chk("ld_c2_done", {31'd0, done}, 32'd1);
    chk("ld_c2_rdata", rdata, 32'hDEADBEEF);
    chk("ld_c2_stall", {31'd0, stall}, 32'd0);
    chk("ld_c2_cyc", {31'd0, cyc}, 32'd0);
    tick();
    settle();
    chk("ld_c3_done", {31'd0, done}, 32'd0);
    chk("ld_c3_stall", {31'd0, stall}, 32'd0);

    // stores with several ack delays
    foreach (dly[k]) begin
      d0 = done_cnt;
      req = 1'b1; we = 1'b1; addr = 32'h0000_2000 + k * 4;
      sel = 4'b0001; wdata = 32'h12345678;
      tick();
      req = 1'b1; we = 1'b0; sel = 4'b1111; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < dly[k]; i++) begin
        settle();
        chk("st_busy_dat", wb_dat, 32'h12345678);
        chk("st_busy_ctl", {27'd0, cyc, wb_we, wb_sel}, 32'h31);
        tick();
      end
      settle();
      chk("st_last_adr", wb_adr, 32'h0000_2000 + k * 4);
      ack = 1'b1; wb_din = 32'hCAFE_F00D;
      tick();
      ack = 1'b0; req = 1'b0;
      settle();
      chk("st_done", {31'd0, done}, 32'd1);
      chk("st_rdata", rdata, 32'd0);
      tick();
      chk("st_one_strobe", done_cnt - d0, 32'd1);
    end

    // flush in 2nd BUSY cycle, ack in 4th
    d0 = done_cnt;
    req = 1'b1; we = 1'b0; addr = 32'h0000_3000; sel = 4'b1111;
    tick();
    tick();
    req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("fl_b3_cyc", {31'd0, cyc}, 32'd1);
    tick();
    settle();
    chk("fl_b4_cyc", {31'd0, cyc}, 32'd1);
    ack = 1'b1; wb_din = 32'h0BAD_0BAD;
    tick();
    ack = 1'b0;
    settle();
    chk("fl_done_state_cyc", {31'd0, cyc}, 32'd0);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_done", {31'd0, done}, 32'd0);
    tick();
    chk("fl_no_strobe", done_cnt - d0, 32'd0);

    // reset pulse during BUSY
    req = 1'b1; we = 1'b1; addr = 32'h0000_4000; sel = 4'b0011;
    wdata = 32'h5555_AAAA;
    tick();
    req = 1'b0;
    settle();
    chk("rb_cyc_before", {31'd0, cyc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rb_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rb_outs", {wb_sel, 1'b0, wb_we, done, stall, err}, 32'd0);
    chk("rb_adr", wb_adr, 32'd0);
    chk("rb_dat", wb_dat, 32'd0);
    chk("rb_rdata", rdata, 32'd0);
    #1 rst = 1'b0;
    tick();
    req = 1'b1; we = 1'b0; addr = 32'h0000_4008; sel = 4'b1111;
    tick();
    ack = 1'b1; wb_din = 32'hA5A5_5A5A;
    tick();
    ack = 1'b0; req = 1'b0;
    settle();
    chk("rb_after_done", {31'd0, done}, 32'd1);
    chk("rb_after_rdata", rdata, 32'hA5A5_5A5A);
    tick();

    // back-to-back loads with req held across DONE
    d0 = done_cnt; c0 = cyc_cnt;
    req = 1'b1; we = 1'b0; addr = 32'h0000_5000; sel = 4'b1111;
    tick();
    ack = 1'b1; wb_din = 32'h1111_2222;
    tick();
    ack = 1'b0; addr = 32'h0000_5010;
    settle();
    chk("bb_done1", rdata, 32'h1111_2222);
    chk("bb_done1_cyc", {31'd0, cyc}, 32'd0);
    tick();
    settle();
    chk("bb_idle_stall", {31'd0, stall}, 32'd1);
    chk("bb_idle_cyc", {31'd0, cyc}, 32'd0);
    tick();
    settle();
    chk("bb_adr2", wb_adr, 32'h0000_5010);
    ack = 1'b1; wb_din = 32'h3333_4444;
    tick();
    ack = 1'b0; req = 1'b0;
    settle();
    chk("bb_rdata2", rdata, 32'h3333_4444);
    tick();
    tick();
    chk("bb_strobes", done_cnt - d0, 32'd2);
    chk("bb_cycles", cyc_cnt - c0, 32'd2);

`ifdef DBUS_TIMEOUT_EN
    // slave never acks
    d0 = done_cnt;
    req = 1'b1; we = 1'b0; addr = 32'h0000_6000; sel = 4'b1111;
    tick();
    for (int i = 0; i < TO; i++) begin
      settle();
      chk("to_busy_cyc", {31'd0, cyc}, 32'd1);
      tick();
    end
    req = 1'b0;
    settle();
    chk("to_cyc", {31'd0, cyc}, 32'd0);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    tick();
    chk("to_one_strobe", done_cnt - d0, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_wb_master.md
# dbus_wb_master

Wishbone classic master for the CPU data bus, sitting between the memory stage and the data-RAM slave, which may insert random wait states. Captures one load/store request, runs one single-beat Wishbone cycle, stalls the pipeline until acknowledge, and returns registered read data. An optional watchdog ends hung cycles with a bus error.

## Interface
- TIMEOUT_CYCLES, 256: BUSY cycles without ack before abort (watchdog builds only); range 2..65535.
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- cpu_req_i  in  1  memory-stage request valid; held until the stall releases.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address.
- cpu_sel_i  in  4  byte enables, already aligned by the CPU.
- cpu_wdata_i  in  32  store data, already lane-shifted.
- cpu_flush_i  in  1  exception/flush; the in-flight result is discarded.
- cpu_stall_o  out  1  holds the pipeline.
- cpu_rdata_o  out  32  load data, valid while cpu_done_o = 1.
- cpu_done_o  out  1  one-cycle completion strobe.
- cpu_err_o  out  1  bus error, qualified by cpu_done_o.
- wb_cyc_o, wb_stb_o  out  1  bus cycle and strobe; always equal.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  {cpu_addr_i[31:2], 2'b00}.
- wb_sel_o  out  4  byte select.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - When cpu_req_i = 1 and cpu_flush_i = 0, register we/adr/sel/dat and go to BUSY.
  - When cpu_req_i = 1 and cpu_flush_i = 1, ignore the request and stay in IDLE.
- BUSY
  - cyc = stb = 1. Bus outputs are stable for the whole cycle.
  - On wb_ack_i: capture wb_dat_i into cpu_rdata_o (stores capture 0) and go to DONE.
- DONE
  - cyc = stb = 0, cpu_stall_o = 0, cpu_done_o = 1 unless the drop flag is set.
  - cpu_req_i is ignored here because it still belongs to the retiring instruction.
  - Always goes to IDLE and clears the drop flag.
- Stall: cpu_stall_o = (IDLE & cpu_req_i & ~cpu_flush_i) | BUSY.
- Flush
  - cpu_flush_i in BUSY sets the drop flag. The Wishbone cycle is never cut short; it runs until ack.
  - With the drop flag set, DONE gives cpu_done_o = 0 and cpu_stall_o = 0.
  - cpu_flush_i in DONE: the result is already retired, so no effect.
- Simultaneous ack and flush in BUSY: ack wins the transition and the drop flag is set, so DONE shows no done strobe.
- Register reset values: state = IDLE, drop = 0, cpu_rdata_o = 0, cpu_err_o = 0, and all wb_* outputs = 0. cpu_done_o = 0 and cpu_stall_o = 0 follow from IDLE.

## Timing
- Request sampled in IDLE at cycle 0. cyc/stb rise in cycle 1, driven from registers.
- Ack sampled at cycle k ≥ 1 gives DONE in cycle k+1, with cpu_rdata_o and cpu_done_o valid. Minimum latency is 2 cycles with cpu_stall_o high.
- Back-to-back requests: IDLE → BUSY → DONE → IDLE. There is at least one idle bus cycle between Wishbone cycles.
- Reset asserted mid-cycle drops cyc/stb asynchronously and returns to IDLE. There is no completion for that request.
- Ack outside BUSY is ignored.

## Configuration
- DBUS_TIMEOUT_EN defined
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, go to DONE with cpu_err_o = 1 and cpu_rdata_o = 0.
  - If ack arrives in the same cycle as the limit, ack wins and cpu_err_o = 0.
- DBUS_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely and cpu_err_o is tied to 0.

## Structure
- Shared package `dbus_pkg`: state enum (IDLE/BUSY/DONE) and the default timeout constant.
- One sub-module, `dbus_watchdog`: the counter with clear, enable and expired; built only under DBUS_TIMEOUT_EN.

## Test plan
- Load, slave acks in the first BUSY cycle, wb_dat_i = 0xDEADBEEF, cpu_addr_i = 0x0000_1006, sel = 4'b1100:
  - wb_adr_o = 0x0000_1004 in cycle 1;
  - cpu_done_o and cpu_rdata_o = 0xDEADBEEF in cycle 2;
  - cpu_stall_o high in cycles 0–1 only.
- Store under random ack delay (0–7 cycles), data 0x12345678, sel 4'b0001:
  - wb_dat_o/wb_sel_o/wb_we_o stable until ack;
  - exactly one done strobe;
  - cpu_rdata_o = 0.
- Flush in the second BUSY cycle, ack in the fourth: cyc stays high until ack, cpu_done_o never asserts, stall releases in DONE.
- wb_rst_i pulsed during BUSY: cyc/stb low within the same cycle and all outputs at reset values. A following request completes normally.
- Back-to-back: two loads with cpu_req_i held across DONE give exactly two Wishbone cycles and two done strobes.
- DBUS_TIMEOUT_EN with TIMEOUT_CYCLES = 8, slave never acks: cyc drops after 8 BUSY cycles and cpu_done_o = 1, cpu_err_o = 1, cpu_rdata_o = 0.
